// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback unit.
//   XLEN / HALF / REG_ADDR_W : datapath and register-address widths
//   wb_state_e               : writeback sequencer states
//   lane_entry_t             : one buffered retired result {rd, data}
package regfile_pkg;

  localparam int XLEN       = 64;
  localparam int HALF       = 32;
  localparam int REG_ADDR_W = 5;

  localparam int NUM_LANES  = 2;
  localparam int LANE_A     = 0;
  localparam int LANE_B     = 1;

  typedef enum logic [1:0] {
    WB_RUN    = 2'd0,
    WB_DRAIN  = 2'd1,
    WB_SWITCH = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } lane_entry_t;

  // Register 0 is hardwired; entries targeting it are consumed without a write.
  function automatic logic is_reg_write(input lane_entry_t e);
    return e.rd != '0;
  endfunction

endpackage

// File: rtl/regfile_writeback_unit_if.sv
// Bus bundle between the execution lanes / register file and the writeback unit.
//   master : producer side (drives lane results and the mode request,
//            observes readies, the write port, mode and idle)
//   slave  : the writeback unit itself
interface regfile_writeback_unit_if;
  import regfile_pkg::*;

  logic                  mode_req;
  logic                  mode;

  logic                  a_valid;
  logic                  a_ready;
  logic [REG_ADDR_W-1:0] a_rd;
  logic [XLEN-1:0]       a_data;

  logic                  b_valid;
  logic                  b_ready;
  logic [REG_ADDR_W-1:0] b_rd;
  logic [XLEN-1:0]       b_data;

  logic                  write_enA;
  logic                  write_enB;
  logic [REG_ADDR_W-1:0] rdA;
  logic [REG_ADDR_W-1:0] rdB;
  logic [XLEN-1:0]       write_data;

  logic                  idle;

  modport master (
    output mode_req,
    output a_valid, a_rd, a_data,
    output b_valid, b_rd, b_data,
    input  mode, a_ready, b_ready,
    input  write_enA, write_enB, rdA, rdB, write_data,
    input  idle
  );

  modport slave (
    input  mode_req,
    input  a_valid, a_rd, a_data,
    input  b_valid, b_rd, b_data,
    output mode, a_ready, b_ready,
    output write_enA, write_enB, rdA, rdB, write_data,
    output idle
  );

endinterface

// File: rtl/wb_lane_fifo.sv
// Per-lane result FIFO.
//   clk, rst    : clock, synchronous flush (drops all entries)
//   push        : write push_entry (ignored when full)
//   pop         : drop the head entry (ignored when empty)
//   full, empty : occupancy flags
//   head        : oldest entry, valid while !empty
// Head is read straight from the array so an entry pushed at one edge can be
// popped at the very next edge.
module wb_lane_fifo
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  lane_entry_t push_entry,
  input  logic        pop,
  output logic        full,
  output logic        empty,
  output lane_entry_t head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  lane_entry_t   mem_reg [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_reg == FULL_COUNT);
  assign empty   = (count_reg == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_reg[rd_ptr_reg];

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= push_entry;
    end
  end

  // DEPTH is a power of two, so the pointers wrap on natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/regfile_writeback_unit.sv
// Writeback unit for the split/unified 64-bit register file.
//   clk, rst : clock, synchronous active-high reset
//   bus      : lane A/B valid/ready result inputs, mode request, the
//              registered register-file write port (write_enA/B, rdA/B,
//              write_data), the current mode and the idle flag
// Each lane is buffered in its own FIFO. In split mode both lanes drain in
// parallel onto their half of the port; in unified mode a round-robin arbiter
// issues one full-width write per cycle on port A. A mode change first stops
// accepting, drains every buffered write, then flips the mode for one cycle.
module regfile_writeback_unit
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter logic        MODE_RESET = 1'b1
) (
  input logic                     clk,
  input logic                     rst,
  regfile_writeback_unit_if.slave bus
);

  wb_state_e state_reg;
  wb_state_e state_next;
  logic      mode_reg;
  logic      mode_next;
  // Round-robin pointer: 0 = lane A has priority, 1 = lane B.
  logic      rr_reg;
  logic      rr_next;

  logic                  write_en_a_reg,  write_en_a_next;
  logic                  write_en_b_reg,  write_en_b_next;
  logic [REG_ADDR_W-1:0] rd_a_reg,        rd_a_next;
  logic [REG_ADDR_W-1:0] rd_b_reg,        rd_b_next;
  logic [XLEN-1:0]       write_data_reg,  write_data_next;

  logic [NUM_LANES-1:0] lane_valid;
  logic [NUM_LANES-1:0] lane_ready;
  logic [NUM_LANES-1:0] lane_push;
  logic [NUM_LANES-1:0] lane_pop;
  logic [NUM_LANES-1:0] lane_full;
  logic [NUM_LANES-1:0] lane_empty;
  lane_entry_t          lane_in   [NUM_LANES];
  lane_entry_t          lane_head [NUM_LANES];

  logic        grant_lane;
  logic        granted;
  lane_entry_t sel_entry;

  assign lane_valid[LANE_A] = bus.a_valid;
  assign lane_valid[LANE_B] = bus.b_valid;
  assign lane_in[LANE_A]    = '{rd: bus.a_rd, data: bus.a_data};
  assign lane_in[LANE_B]    = '{rd: bus.b_rd, data: bus.b_data};

  // ------------------------------------------------------------------
  // Lane buffers. Ready looks only at state and fullness, never at valid,
  // so a full FIFO refuses even when it is popping in the same cycle.
  // ------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    assign lane_ready[gi] = (state_reg == WB_RUN) & ~lane_full[gi] & ~rst;
    assign lane_push[gi]  = lane_valid[gi] & lane_ready[gi];

    wb_lane_fifo #(
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (lane_push[gi]),
      .push_entry (lane_in[gi]),
      .pop        (lane_pop[gi]),
      .full       (lane_full[gi]),
      .empty      (lane_empty[gi]),
      .head       (lane_head[gi])
    );
  end

  // ------------------------------------------------------------------
  // Issue selection for the next port cycle. Issuing continues in every
  // state; while draining it empties the FIFOs in the current mode.
  // ------------------------------------------------------------------
  always_comb begin
    lane_pop        = '0;
    rr_next         = rr_reg;
    grant_lane      = 1'b0;
    granted         = 1'b0;
    sel_entry       = '0;
    write_en_a_next = 1'b0;
    write_en_b_next = 1'b0;
    rd_a_next       = '0;
    rd_b_next       = '0;
    write_data_next = '0;

    if (mode_reg) begin
      // Unified: one grant per cycle; the pointer moves only on contention.
      if (!lane_empty[LANE_A] && !lane_empty[LANE_B]) begin
        grant_lane = rr_reg;
        granted    = 1'b1;
        rr_next    = ~rr_reg;
      end else if (!lane_empty[LANE_A]) begin
        grant_lane = 1'b0;
        granted    = 1'b1;
      end else if (!lane_empty[LANE_B]) begin
        grant_lane = 1'b1;
        granted    = 1'b1;
      end

      if (granted) begin
        lane_pop[grant_lane] = 1'b1;
        sel_entry            = lane_head[grant_lane];
        // An rd=0 entry still burns its slot but produces no write.
        if (is_reg_write(sel_entry)) begin
          write_en_a_next = 1'b1;
          rd_a_next       = sel_entry.rd;
          write_data_next = sel_entry.data;
        end
      end
    end else begin
      // Split: each lane owns a port and a 32-bit half of write_data.
      lane_pop = ~lane_empty;
      if (!lane_empty[LANE_A] && is_reg_write(lane_head[LANE_A])) begin
        write_en_a_next            = 1'b1;
        rd_a_next                  = lane_head[LANE_A].rd;
        write_data_next[HALF-1:0]  = lane_head[LANE_A].data[HALF-1:0];
      end
      if (!lane_empty[LANE_B] && is_reg_write(lane_head[LANE_B])) begin
        write_en_b_next              = 1'b1;
        rd_b_next                    = lane_head[LANE_B].rd;
        write_data_next[XLEN-1:HALF] = lane_head[LANE_B].data[HALF-1:0];
      end
    end
  end

  // ------------------------------------------------------------------
  // Mode sequencer.
  // ------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    mode_next  = mode_reg;
    unique case (state_reg)
      WB_RUN: begin
        if (bus.mode_req != mode_reg) begin
          state_next = WB_DRAIN;
        end
      end
      WB_DRAIN: begin
        // The last popped write is still on the port for one cycle after the
        // FIFOs go empty; wait for it so the switch never splits a write.
        if ((&lane_empty) && !write_en_a_reg && !write_en_b_reg) begin
          state_next = WB_SWITCH;
        end
      end
      WB_SWITCH: begin
        // The request may have reverted while draining; take whatever it is now.
        mode_next  = bus.mode_req;
        state_next = WB_RUN;
      end
      default: begin
        state_next = WB_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= WB_RUN;
      mode_reg       <= MODE_RESET;
      rr_reg         <= 1'b0;
      write_en_a_reg <= 1'b0;
      write_en_b_reg <= 1'b0;
      rd_a_reg       <= '0;
      rd_b_reg       <= '0;
      write_data_reg <= '0;
    end else begin
      state_reg      <= state_next;
      mode_reg       <= mode_next;
      rr_reg         <= rr_next;
      write_en_a_reg <= write_en_a_next;
      write_en_b_reg <= write_en_b_next;
      rd_a_reg       <= rd_a_next;
      rd_b_reg       <= rd_b_next;
      write_data_reg <= write_data_next;
    end
  end

  assign bus.a_ready    = lane_ready[LANE_A];
  assign bus.b_ready    = lane_ready[LANE_B];
  assign bus.mode       = mode_reg;
  assign bus.write_enA  = write_en_a_reg;
  assign bus.write_enB  = write_en_b_reg;
  assign bus.rdA        = rd_a_reg;
  assign bus.rdB        = rd_b_reg;
  assign bus.write_data = write_data_reg;
  assign bus.idle       = (&lane_empty) & ~write_en_a_reg & ~write_en_b_reg &
                          (state_reg == WB_RUN);

endmodule

// File: tb/tb_regfile_writeback_unit.sv
// Self-checking bench for regfile_writeback_unit.
module tb_regfile_writeback_unit;
  import regfile_pkg::*;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_writeback_unit_if bus ();

  regfile_writeback_unit #(
    .DEPTH      (DEPTH),
    .MODE_RESET (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks;
  int n_fail;

  typedef struct {
    logic        mode;
    logic        av;
    logic [4:0]  ar;
    logic [63:0] ad;
    logic        bv;
    logic [4:0]  br;
    logic [63:0] bd;
    logic        ea;
    logic        eb;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [63:0] wd;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pat(input logic [4:0] r);
    return {8{3'b000, r}};
  endfunction

  task automatic clear_inputs();
    bus.a_valid = 1'b0; bus.a_rd = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_rd = '0; bus.b_data = '0;
  endtask

  task automatic drive_a(input logic v, input logic [4:0] r, input logic [63:0] d);
    bus.a_valid = v; bus.a_rd = r; bus.a_data = d;
  endtask

  task automatic drive_b(input logic v, input logic [4:0] r, input logic [63:0] d);
    bus.b_valid = v; bus.b_rd = r; bus.b_data = d;
  endtask

  function automatic logic [63:0] port_word();
    return 64'({bus.write_enA, bus.write_enB, bus.rdA, bus.rdB});
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    bus.mode_req = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    #1;
  endtask

  task automatic set_mode(input logic m);
    bit done = 0;
    bus.mode_req = m;
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      if (bus.mode === m && bus.idle === 1'b1) done = 1;
    end
    check("set_mode reached", 64'(done), 64'd1);
  endtask

  // Unified contention: both lanes stream three entries from the same edges.
  task automatic contention();
    int a_i = 0;
    int b_i = 0;
    bit saw_stall = 0;
    int en_b_seen = 0;
    logic [4:0]  got_rd [$];
    logic [63:0] got_d  [$];
    int exp_seq [6] = '{1, 11, 2, 12, 3, 13};
    for (int cyc = 0; cyc < 16; cyc++) begin
      bit acc_a, acc_b;
      if (bus.write_enA) begin
        got_rd.push_back(bus.rdA);
        got_d.push_back(bus.write_data);
      end
      if (bus.write_enB) en_b_seen++;
      drive_a(a_i < 3, 5'(a_i + 1), pat(5'(a_i + 1)));
      drive_b(b_i < 3, 5'(b_i + 11), pat(5'(b_i + 11)));
      if (cyc > 0 && (!bus.a_ready || !bus.b_ready)) saw_stall = 1;
      acc_a = bus.a_valid && bus.a_ready;
      acc_b = bus.b_valid && bus.b_ready;
      step();
      if (acc_a) a_i++;
      if (acc_b) b_i++;
    end
    clear_inputs();
    check("contention ready stall", 64'(saw_stall), 64'd1);
    check("contention enB", 64'(en_b_seen), 64'd0);
    check("contention count", 64'(got_rd.size()), 64'd6);
    for (int i = 0; i < 6 && i < got_rd.size(); i++) begin
      check($sformatf("contention rd[%0d]", i), 64'(got_rd[i]), 64'(exp_seq[i]));
      check($sformatf("contention data[%0d]", i), got_d[i], pat(5'(exp_seq[i])));
    end
    $display("contention: %0d writes issued on port A", got_rd.size());
  endtask

  task automatic rd0_discard();
    drive_a(1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    drive_a(1'b1, 5'd4, pat(5'd4));
    step();
    clear_inputs();
    check("rd0 slot port", port_word(), 64'd0);
    check("rd0 slot data", bus.write_data, 64'd0);
    step();
    check("rd0 next port", port_word(), 64'({1'b1, 1'b0, 5'd4, 5'd0}));
    check("rd0 next data", bus.write_data, pat(5'd4));
    step();
    check("rd0 idle", 64'(bus.idle), 64'd1);
    $display("rd0 discard sequence done");
  endtask

  task automatic mode_switch();
    drive_a(1'b1, 5'd2, pat(5'd2));
    step();
    drive_a(1'b1, 5'd3, pat(5'd3));
    bus.mode_req = 1'b0;
    check("msw ready before", 64'(bus.a_ready), 64'd1);
    step();
    clear_inputs();
    check("msw ready drain", 64'({bus.a_ready, bus.b_ready}), 64'd0);
    check("msw w1 port", port_word(), 64'({1'b1, 1'b0, 5'd2, 5'd0}));
    check("msw w1 data", bus.write_data, pat(5'd2));
    step();
    check("msw w2 port", port_word(), 64'({1'b1, 1'b0, 5'd3, 5'd0}));
    check("msw w2 data", bus.write_data, pat(5'd3));
    check("msw mode w2", 64'(bus.mode), 64'd1);
    step();
    check("msw quiet port", port_word(), 64'd0);
    check("msw quiet idle", 64'(bus.idle), 64'd0);
    step();
    check("msw switch mode", 64'(bus.mode), 64'd1);
    check("msw switch ready", 64'(bus.a_ready), 64'd0);
    step();
    check("msw run mode", 64'(bus.mode), 64'd0);
    check("msw run ready", 64'({bus.a_ready, bus.b_ready}), 64'd3);
    check("msw run idle", 64'(bus.idle), 64'd1);
    $display("mode switch sequence done, mode=%0d", bus.mode);
  endtask

  task automatic reset_mid_drain();
    int en_seen = 0;
    drive_a(1'b1, 5'd2, pat(5'd2));
    step();
    drive_a(1'b1, 5'd3, pat(5'd3));
    bus.mode_req = 1'b0;
    step();
    clear_inputs();
    bus.mode_req = 1'b1;
    rst = 1'b1;
    step();
    check("rstdrain port", port_word(), 64'd0);
    check("rstdrain data", bus.write_data, 64'd0);
    check("rstdrain mode", 64'(bus.mode), 64'd1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.write_enA || bus.write_enB) en_seen++;
    end
    check("rstdrain no enables", 64'(en_seen), 64'd0);
    check("rstdrain idle", 64'(bus.idle), 64'd1);
    check("rstdrain mode after", 64'(bus.mode), 64'd1);
    $display("reset mid-drain sequence done");
  endtask

  // Random traffic against a queue-based reference. Mode is held fixed; the
  // unified pointer is assumed to start at lane A (fresh reset).
  task automatic run_random(input int cycles, input string tag, input logic m);
    lane_entry_t qa [$];
    lane_entry_t qb [$];
    logic        pri_b = 1'b0;
    logic        e_ea = 0, e_eb = 0;
    logic [4:0]  e_ra = 0, e_rb = 0;
    logic [63:0] e_wd = 0;
    for (int c = 0; c < cycles + 8; c++) begin
      bit rdy_a, rdy_b, active;
      lane_entry_t e;
      int pick;
      check({tag, " port"}, port_word(), 64'({e_ea, e_eb, e_ra, e_rb}));
      check({tag, " data"}, bus.write_data, e_wd);
      if (bus.write_enA) $display("%s write A rd=%0d data=%h", tag, bus.rdA, bus.write_data);
      if (bus.write_enB) $display("%s write B rd=%0d data=%h", tag, bus.rdB, bus.write_data);

      active = (c < cycles);
      drive_a(active && ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 31)), {$urandom, $urandom});
      drive_b(active && ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 31)), {$urandom, $urandom});
      rdy_a = (qa.size() < DEPTH);
      rdy_b = (qb.size() < DEPTH);
      check({tag, " ready"}, 64'({bus.a_ready, bus.b_ready}), 64'({rdy_a, rdy_b}));

      e_ea = 0; e_eb = 0; e_ra = 0; e_rb = 0; e_wd = 0;
      if (m) begin
        pick = -1;
        if (qa.size() > 0 && qb.size() > 0) begin
          pick = pri_b ? 1 : 0;
          pri_b = ~pri_b;
        end else if (qa.size() > 0) pick = 0;
        else if (qb.size() > 0) pick = 1;
        if (pick >= 0) begin
          e = (pick == 1) ? qb.pop_front() : qa.pop_front();
          if (e.rd != 0) begin
            e_ea = 1; e_ra = e.rd; e_wd = e.data;
          end
        end
      end else begin
        if (qa.size() > 0) begin
          e = qa.pop_front();
          if (e.rd != 0) begin
            e_ea = 1; e_ra = e.rd; e_wd[31:0] = e.data[31:0];
          end
        end
        if (qb.size() > 0) begin
          e = qb.pop_front();
          if (e.rd != 0) begin
            e_eb = 1; e_rb = e.rd; e_wd[63:32] = e.data[31:0];
          end
        end
      end
      if (bus.a_valid && rdy_a) begin
        e.rd = bus.a_rd; e.data = bus.a_data; qa.push_back(e);
      end
      if (bus.b_valid && rdy_b) begin
        e.rd = bus.b_rd; e.data = bus.b_data; qb.push_back(e);
      end
      step();
    end
    clear_inputs();
    check({tag, " final idle"}, 64'(bus.idle), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;

    tbl[0] = '{1'b1, 1'b1, 5'd5,  64'h1122_3344_5566_7788, 1'b0, 5'd0,  64'h0,
               1'b1, 1'b0, 5'd5,  5'd0,  64'h1122_3344_5566_7788};
    tbl[1] = '{1'b1, 1'b0, 5'd0,  64'h0, 1'b1, 5'd9,  64'hDEAD_BEEF_CAFE_F00D,
               1'b1, 1'b0, 5'd9,  5'd0,  64'hDEAD_BEEF_CAFE_F00D};
    tbl[2] = '{1'b1, 1'b1, 5'd0,  64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5'd0, 64'h0,
               1'b0, 1'b0, 5'd0,  5'd0,  64'h0};
    tbl[3] = '{1'b1, 1'b1, 5'd31, 64'h8000_0000_0000_0001, 1'b0, 5'd0, 64'h0,
               1'b1, 1'b0, 5'd31, 5'd0,  64'h8000_0000_0000_0001};
    tbl[4] = '{1'b0, 1'b1, 5'd7,  64'h9999_9999_AAAA_5555, 1'b1, 5'd7, 64'h7777_7777_1234_5678,
               1'b1, 1'b1, 5'd7,  5'd7,  64'h1234_5678_AAAA_5555};
    tbl[5] = '{1'b0, 1'b1, 5'd3,  64'h0123_4567_89AB_CDEF, 1'b0, 5'd0, 64'h0,
               1'b1, 1'b0, 5'd3,  5'd0,  64'h0000_0000_89AB_CDEF};
    tbl[6] = '{1'b0, 1'b0, 5'd0,  64'h0, 1'b1, 5'd30, 64'hFEDC_BA98_7654_3210,
               1'b0, 1'b1, 5'd0,  5'd30, 64'h7654_3210_0000_0000};
    tbl[7] = '{1'b0, 1'b1, 5'd0,  64'h1234_1234_1234_1234, 1'b1, 5'd1, 64'h0000_0000_55AA_55AA,
               1'b0, 1'b1, 5'd0,  5'd1,  64'h55AA_55AA_0000_0000};

    // Reset behaviour.
    rst = 1'b1;
    clear_inputs();
    bus.mode_req = 1'b1;
    step();
    check("reset ready", 64'({bus.a_ready, bus.b_ready}), 64'd0);
    step();
    check("reset mode", 64'(bus.mode), 64'd1);
    check("reset port", port_word(), 64'd0);
    check("reset data", bus.write_data, 64'd0);
    rst = 1'b0;
    #1;
    check("post-reset ready", 64'({bus.a_ready, bus.b_ready}), 64'd3);
    check("post-reset idle", 64'(bus.idle), 64'd1);
    $display("reset sequence done");

    contention();

    do_reset();
    rd0_discard();

    for (int i = 0; i < 8; i++) begin
      if (bus.mode !== tbl[i].mode) set_mode(tbl[i].mode);
      drive_a(tbl[i].av, tbl[i].ar, tbl[i].ad);
      drive_b(tbl[i].bv, tbl[i].br, tbl[i].bd);
      check($sformatf("tbl%0d ready", i), 64'({bus.a_ready, bus.b_ready}), 64'd3);
      step();
      clear_inputs();
      step();
      check($sformatf("tbl%0d port", i), port_word(),
            64'({tbl[i].ea, tbl[i].eb, tbl[i].ra, tbl[i].rb}));
      check($sformatf("tbl%0d data", i), bus.write_data, tbl[i].wd);
      $display("vec %0d mode=%0d enA=%0b enB=%0b rdA=%0d rdB=%0d data=%h",
               i, bus.mode, bus.write_enA, bus.write_enB, bus.rdA, bus.rdB, bus.write_data);
      step();
      check($sformatf("tbl%0d idle", i), 64'(bus.idle), 64'd1);
    end

    do_reset();
    mode_switch();

    do_reset();
    reset_mid_drain();

    do_reset();
    run_random(150, "uni", 1'b1);
    set_mode(1'b0);
    run_random(150, "split", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
